// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU op encoding, forwarding source tags and width defaults.
package pipe_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REGW_DEF = 5;

    localparam logic [4:0] ALUC_ADD    = 5'b00000;
    localparam logic [4:0] ALUC_SLL    = 5'b00001;
    localparam logic [4:0] ALUC_SLT    = 5'b00010;
    localparam logic [4:0] ALUC_SLTU   = 5'b00011;
    localparam logic [4:0] ALUC_XOR    = 5'b00100;
    localparam logic [4:0] ALUC_SRL    = 5'b00101;
    localparam logic [4:0] ALUC_OR     = 5'b00110;
    localparam logic [4:0] ALUC_AND    = 5'b00111;
    localparam logic [4:0] ALUC_SUB    = 5'b01000;
    localparam logic [4:0] ALUC_SRA    = 5'b01101;
    localparam logic [4:0] ALUC_BUBBLE = ALUC_ADD;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EX,
        FWD_MEM,
        FWD_WB
    } fwd_sel_t;

endpackage

// File: rtl/fwd_mux.sv
// Single-operand bypass selector: picks the youngest in-flight producer of rs, else register file.
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF
) (
    input  logic [REGW-1:0] rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_fwd_en,
    input  logic [REGW-1:0] ex_rd,
    input  logic [XLEN-1:0] ex_r,
    input  logic            mem_fwd_en,
    input  logic [REGW-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_wreg,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] value
);

    fwd_sel_t sel;

    always_comb begin
        sel = FWD_RF;
        if (rs != '0) begin
            if (ex_fwd_en && (ex_rd == rs)) begin
                sel = FWD_EX;
            end else if (mem_fwd_en && (mem_rd == rs)) begin
                sel = FWD_MEM;
            end else if (wb_wreg && (wb_rd == rs)) begin
                sel = FWD_WB;
            end
        end
    end

    // x0 reads as zero whatever the register file returns.
    always_comb begin
        value = rf_data;
        case (sel)
            FWD_EX:  value = ex_r;
            FWD_MEM: value = mem_result;
            FWD_WB:  value = wb_data;
            default: value = rf_data;
        endcase
        if (rs == '0) begin
            value = '0;
        end
    end

endmodule

// File: rtl/id_ex_issue.sv
// ID->EX issue stage: operand bypass, load-use/RAW stall, flush, and the ID/EX register.
// Build macro IDEX_FWD_EN enables EX/MEM forwarding; without it only WB bypass is kept.
module id_ex_issue
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_aluc,
    input  logic            id_asel,
    input  logic            id_bsel,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_wreg,
    input  logic            id_m2reg,
    input  logic            id_wmem,
    input  logic [XLEN-1:0] ex_r,
    input  logic            mem_wreg,
    input  logic [REGW-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_wreg,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_flush,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_aluc,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_wreg,
    output logic            ex_m2reg,
    output logic            ex_wmem
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] sd_q, sd_d;
    logic [4:0]      aluc_q, aluc_d;
    logic [REGW-1:0] rd_q, rd_d;
    logic            wreg_q, wreg_d;
    logic            m2reg_q, m2reg_d;
    logic            wmem_q, wmem_d;

    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    logic            ex_fwd_en, mem_fwd_en;
    logic            rs1_hit, rs2_hit;
    logic            hazard, issue;

`ifdef IDEX_FWD_EN
    // A load's result is not ready in EX, so loads are excluded from EX forwarding.
    assign ex_fwd_en  = valid_q & wreg_q & ~m2reg_q;
    assign mem_fwd_en = mem_wreg;
    assign rs1_hit    = id_rs1_used & (rd_q == id_rs1);
    assign rs2_hit    = id_rs2_used & (rd_q == id_rs2);
    assign hazard     = id_valid & valid_q & m2reg_q & (rd_q != '0) & (rs1_hit | rs2_hit);
`else
    assign ex_fwd_en  = 1'b0;
    assign mem_fwd_en = 1'b0;
    // Any EX or MEM producer of a used non-zero source blocks issue until it reaches WB.
    assign rs1_hit    = id_rs1_used & (id_rs1 != '0) &
                        ((valid_q & wreg_q & (rd_q == id_rs1)) | (mem_wreg & (mem_rd == id_rs1)));
    assign rs2_hit    = id_rs2_used & (id_rs2 != '0) &
                        ((valid_q & wreg_q & (rd_q == id_rs2)) | (mem_wreg & (mem_rd == id_rs2)));
    assign hazard     = id_valid & (rs1_hit | rs2_hit);
`endif

    assign stall = hazard & ~ex_flush;
    assign issue = id_valid & ~ex_flush & ~hazard;

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
        .rs         (id_rs1),
        .rf_data    (id_rs1_data),
        .ex_fwd_en  (ex_fwd_en),
        .ex_rd      (rd_q),
        .ex_r       (ex_r),
        .mem_fwd_en (mem_fwd_en),
        .mem_rd     (mem_rd),
        .mem_result (mem_result),
        .wb_wreg    (wb_wreg),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .value      (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
        .rs         (id_rs2),
        .rf_data    (id_rs2_data),
        .ex_fwd_en  (ex_fwd_en),
        .ex_rd      (rd_q),
        .ex_r       (ex_r),
        .mem_fwd_en (mem_fwd_en),
        .mem_rd     (mem_rd),
        .mem_result (mem_result),
        .wb_wreg    (wb_wreg),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .value      (fwd_rs2)
    );

    always_comb begin
        valid_d = 1'b0;
        pc_d    = '0;
        a_d     = '0;
        b_d     = '0;
        sd_d    = '0;
        aluc_d  = ALUC_BUBBLE;
        rd_d    = '0;
        wreg_d  = 1'b0;
        m2reg_d = 1'b0;
        wmem_d  = 1'b0;
        if (issue) begin
            valid_d = 1'b1;
            pc_d    = id_pc;
            a_d     = id_asel ? id_pc : fwd_rs1;
            b_d     = id_bsel ? id_imm : fwd_rs2;
            sd_d    = fwd_rs2;
            aluc_d  = id_aluc;
            rd_d    = id_rd;
            wreg_d  = id_wreg;
            m2reg_d = id_m2reg;
            wmem_d  = id_wmem;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sd_q    <= '0;
            aluc_q  <= ALUC_BUBBLE;
            rd_q    <= '0;
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            wmem_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sd_q    <= sd_d;
            aluc_q  <= aluc_d;
            rd_q    <= rd_d;
            wreg_q  <= wreg_d;
            m2reg_q <= m2reg_d;
            wmem_q  <= wmem_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_a          = a_q;
    assign ex_b          = b_q;
    assign ex_store_data = sd_q;
    assign ex_aluc       = aluc_q;
    assign ex_rd         = rd_q;
    assign ex_wreg       = wreg_q;
    assign ex_m2reg      = m2reg_q;
    assign ex_wmem       = wmem_q;

endmodule

// File: doc/id_ex_issue.md
Name: id_ex_issue

Overview:
- ID→EX issue stage of the 5-stage RISC-V pipeline; feeds the ALU's a, b and aluc directly from registered outputs.
- Resolves RAW hazards by forwarding from EX, MEM and WB into the operand path before the ID/EX latch.
- Detects load-use hazards, raises stall, and inserts a bubble.
- Handles branch/jump flush from EX.

Parameters:
XLEN, 32, datapath width
REGW, 5, register index width

Ports:
clk  in  1  clock, rising edge
clrn  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1, id_rs2  in  REGW  source register indices
id_rs1_used, id_rs2_used  in  1  instruction reads rs1/rs2
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  decoded immediate (already shifted for LUI/AUIPC)
id_aluc  in  5  ALU op code, codebase aluc encoding
id_asel  in  1  0: a=rs1 value, 1: a=pc
id_bsel  in  1  0: b=rs2 value, 1: b=imm
id_rd  in  REGW  destination index
id_wreg, id_m2reg, id_wmem  in  1  writes reg / is load / is store
ex_r  in  XLEN  current ALU result (EX stage)
mem_wreg  in  1  MEM-stage write enable
mem_rd  in  REGW  MEM-stage destination
mem_result  in  XLEN  MEM-stage final value
wb_wreg  in  1  WB-stage write enable
wb_rd  in  REGW  WB-stage destination
wb_data  in  XLEN  WB-stage write data
ex_flush  in  1  EX redirect (taken branch/jump)
stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_pc, ex_a, ex_b, ex_store_data  out  XLEN  registered operands
ex_aluc  out  5  registered ALU op
ex_rd  out  REGW  registered destination
ex_wreg, ex_m2reg, ex_wmem  out  1  registered control

Behaviour:
- Reset (clrn=0, async): all outputs 0. ex_aluc=00000 (ADD) with ex_wreg=0 is the canonical bubble.
- Latency: one clock. Values captured at rising clk appear on ex_* the same cycle.
- Forward source per operand, priority order:
  - EX: ex_valid & ex_wreg & !ex_m2reg & ex_rd==rs → ex_r
  - MEM: mem_wreg & mem_rd==rs → mem_result
  - WB: wb_wreg & wb_rd==rs → wb_data
  - else register-file data
  - rs==0 never forwarded; value is 0.
- Operand muxes:
  - ex_a = asel ? id_pc : fwd_rs1
  - ex_b = bsel ? id_imm : fwd_rs2
  - ex_store_data = fwd_rs2, always
- Load-use: ex_valid & ex_m2reg & ex_rd!=0 & ((id_rs1_used & ex_rd==id_rs1) | (id_rs2_used & ex_rd==id_rs2)) & id_valid
  - stall=1 (combinational).
  - Register loads bubble: valid/wreg/m2reg/wmem=0, aluc=0, data fields 0.
  - Released next cycle; the load is then in MEM and covered by MEM forwarding.
- Flush: ex_flush=1 → register loads bubble; stall forced 0. Flush beats stall and beats a valid ID instruction.
- id_valid=0 → bubble loaded; stall=0.
- Simultaneous EX and MEM match on the same rs: EX wins (youngest).
- Reset asserted mid-stall: outputs clear immediately; stall drops to 0.

Optional Feature:
IDEX_FWD_EN
- Defined: forwarding as above.
- Undefined: EX and MEM forwarding removed; WB bypass retained.
  - stall=1 whenever a used rs≠0 matches a writing EX instruction (ex_valid & ex_wreg) or a MEM instruction (mem_wreg).
  - Each stalled cycle inserts a bubble.
  - Flush still overrides stall.

Decomposition:
- Package pipe_pkg:
  - ALUC_* constants for the aluc encoding, ALUC_BUBBLE=5'b00000.
  - fwd_sel_t enum {FWD_RF, FWD_EX, FWD_MEM, FWD_WB}.
  - XLEN/REGW defaults.
- Sub-module fwd_mux: one operand's source select and value, instantiated twice (rs1, rs2). Pure combinational.
- Hazard logic and pipeline register live in id_ex_issue.

Test Plan:
- Reset then release; id: add x3,x1,x2 with rf x1=5, x2=7, no hazards → next cycle ex_a=5, ex_b=7, ex_aluc=00000, ex_rd=3, ex_wreg=1, ex_valid=1.
- Back-to-back RAW: EX holds rd=3, ex_r=12; ID sub x4,x3,x1 with rf x3=0 → ex_a=12, ex_b=5, stall=0.
- Priority: EX rd=3 ex_r=1, MEM rd=3 mem_result=2, WB rd=3 wb_data=3 → ex_a=1. Same with EX not writing → 2. With MEM also idle → 3.
- Load-use: EX lw x5 (m2reg=1); ID add x6,x5,x0 → stall=1 one cycle, bubble (ex_valid=0, ex_wreg=0). Next cycle mem_rd=5, mem_result=0xDEADBEEF → ex_a=0xDEADBEEF, stall=0.
- Flush during load-use: same as above plus ex_flush=1 → stall=0, bubble loaded, no instruction issued. x0 source with EX rd=0 writing ex_r=9 → operand 0.
- IDEX_FWD_EN undefined: EX rd=3 writing; ID uses x3 → stall two cycles (EX then MEM), issue on third cycle with rf/WB value.
